// File: rtl/wb_arb_pkg.sv
// Shared state encoding, priority-mode constants and a constant-safe log2
// used by the Wishbone multi-master arbiter.
package wb_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Rotating priority encoder: first requester at or after the start index wins.
// FIXED mode forces the start to 0 so the lowest index always wins.
module wb_arb_pick
   import wb_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic             mode_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   int start_idx;

   // Scanning from the far end down lets the nearest requester overwrite the rest.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch.
      start_idx = (mode_i == ARB_FIXED) ? 0 : int'(ptr_i);
      valid_o   = |req_i;
      idx_o     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(start_idx + k) % N]) idx_o = IDX_W'((start_idx + k) % N);
      end
   end

endmodule

// File: rtl/wb_mux_arbiter.sv
// Wishbone classic arbiter: NUM_MASTERS single-transfer masters share one slave
// port, with fixed or round-robin priority and a hung-transfer watchdog.
module wb_mux_arbiter
   import wb_arb_pkg::*;
#(
   parameter int    NUM_MASTERS = 2,
   parameter int    ADDR_W      = 32,
   parameter int    DATA_W      = 32,
   parameter string ARB_MODE    = "RR",
   parameter int    TIMEOUT     = 256,
   localparam int   SEL_W       = DATA_W / 8,
   localparam int   IDX_W       = clog2(NUM_MASTERS)
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_dat,
   input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
   input  logic [NUM_MASTERS-1:0]        m_we,
   input  logic [NUM_MASTERS-1:0]        m_cyc,
   output logic [DATA_W-1:0]             m_rdt,
   output logic [NUM_MASTERS-1:0]        m_ack,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [ADDR_W-1:0]             s_adr,
   output logic [DATA_W-1:0]             s_dat,
   output logic [SEL_W-1:0]              s_sel,
   output logic                          s_we,
   output logic                          s_cyc,
   output logic                          s_stb,
   input  logic [DATA_W-1:0]             s_rdt,
   input  logic                          s_ack,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          busy,
   output logic                          timeout_evt
);

   localparam int               WDT_W    = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
   localparam logic             MODE     = (ARB_MODE == "FIXED") ? ARB_FIXED : ARB_RR;
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WDT_W-1:0] WDT_MAX  = '1;

   arb_state_e       state_q;
   logic [IDX_W-1:0] grant_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [WDT_W-1:0] wdt_q;
   logic [WDT_W-1:0] wdt_d;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             in_busy;
   logic             gnt_cyc;
   logic             ack_hit;
   logic             wdt_fire;
   logic             xfer_end;

   wb_arb_pick #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (m_cyc),
      .ptr_i   (ptr_q),
      .mode_i  (MODE),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign in_busy  = (state_q == BUSY);
   assign gnt_cyc  = m_cyc[grant_q];
   assign ack_hit  = in_busy & gnt_cyc & s_ack;
   // An ack in the last watchdog cycle still completes the transfer normally.
   assign wdt_fire = (TIMEOUT > 0) && in_busy && gnt_cyc && !s_ack && (wdt_q == WDT_LAST);
   assign xfer_end = ack_hit | wdt_fire | ~gnt_cyc;

   assign ptr_d = IDX_W'((int'(pick_idx) + 1) % NUM_MASTERS);
   assign wdt_d = (wdt_q == WDT_MAX) ? wdt_q : wdt_q + 1'b1;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge wb_clk) begin
      if (!wb_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         wdt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= BUSY;
                  grant_q <= pick_idx;
                  ptr_q   <= ptr_d;
                  wdt_q   <= '0;
               end
            end
            BUSY: begin
               if (xfer_end) state_q <= IDLE;
               else          wdt_q   <= wdt_d;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = in_busy;
   assign grant_idx   = grant_q;
   assign timeout_evt = wdt_fire;
   assign m_rdt       = s_rdt;

   assign s_cyc = in_busy & gnt_cyc & ~wdt_fire;
   assign s_stb = s_cyc;
   assign s_adr = m_adr[int'(grant_q) * ADDR_W +: ADDR_W];
   assign s_dat = m_dat[int'(grant_q) * DATA_W +: DATA_W];
   assign s_sel = m_sel[int'(grant_q) * SEL_W +: SEL_W];
   assign s_we  = m_we[grant_q];

   always_comb begin
      m_ack          = '0;
      m_err          = '0;
      m_ack[grant_q] = ack_hit;
      m_err[grant_q] = wdt_fire;
   end

endmodule

// File: tb/tb_wb_mux_arbiter.sv
// Self-checking bench: RR/FIXED 4-master instances plus a 2-master FIXED instance,
// directed corner sequences, a grant table and a randomized run against a model.
module tb_wb_mux_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int N  = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_dat;
   logic [N*SW-1:0] m_sel;
   logic [N-1:0]    m_we;
   logic [N-1:0]    m_cyc;
   logic [DW-1:0]   s_rdt;
   logic            s_ack_drv;
   logic            zw;

   logic [DW-1:0] rr_rdt, rr_sdat, fx_rdt, fx_sdat, t2_rdt, t2_sdat;
   logic [AW-1:0] rr_sadr, fx_sadr, t2_sadr;
   logic [SW-1:0] rr_ssel, fx_ssel, t2_ssel;
   logic          rr_swe, rr_scyc, rr_sstb, rr_busy, rr_evt, rr_sack;
   logic          fx_swe, fx_scyc, fx_sstb, fx_busy, fx_evt, fx_sack;
   logic          t2_swe, t2_scyc, t2_sstb, t2_busy, t2_evt, t2_sack;
   logic [N-1:0]  rr_ack, rr_err, fx_ack, fx_err;
   logic [1:0]    t2_ack, t2_err;
   logic [1:0]    rr_gnt, fx_gnt;
   logic [0:0]    t2_gnt;

   // Zero-wait slave mode acks whenever its transfer is outstanding.
   assign rr_sack = s_ack_drv | (zw & rr_busy & m_cyc[rr_gnt]);
   assign fx_sack = s_ack_drv | (zw & fx_busy & m_cyc[fx_gnt]);
   assign t2_sack = s_ack_drv | (zw & t2_busy & m_cyc[t2_gnt]);

   wb_mux_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE("RR"), .TIMEOUT(TO)) u_rr (
      .wb_clk(clk), .wb_rst(rst_n), .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel), .m_we(m_we),
      .m_cyc(m_cyc), .m_rdt(rr_rdt), .m_ack(rr_ack), .m_err(rr_err), .s_adr(rr_sadr),
      .s_dat(rr_sdat), .s_sel(rr_ssel), .s_we(rr_swe), .s_cyc(rr_scyc), .s_stb(rr_sstb),
      .s_rdt(s_rdt), .s_ack(rr_sack), .grant_idx(rr_gnt), .busy(rr_busy), .timeout_evt(rr_evt));

   wb_mux_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE("FIXED"), .TIMEOUT(TO)) u_fx (
      .wb_clk(clk), .wb_rst(rst_n), .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel), .m_we(m_we),
      .m_cyc(m_cyc), .m_rdt(fx_rdt), .m_ack(fx_ack), .m_err(fx_err), .s_adr(fx_sadr),
      .s_dat(fx_sdat), .s_sel(fx_ssel), .s_we(fx_swe), .s_cyc(fx_scyc), .s_stb(fx_sstb),
      .s_rdt(s_rdt), .s_ack(fx_sack), .grant_idx(fx_gnt), .busy(fx_busy), .timeout_evt(fx_evt));

   wb_mux_arbiter #(.NUM_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE("FIXED"), .TIMEOUT(0)) u_t2 (
      .wb_clk(clk), .wb_rst(rst_n), .m_adr(m_adr[2*AW-1:0]), .m_dat(m_dat[2*DW-1:0]),
      .m_sel(m_sel[2*SW-1:0]), .m_we(m_we[1:0]), .m_cyc(m_cyc[1:0]), .m_rdt(t2_rdt),
      .m_ack(t2_ack), .m_err(t2_err), .s_adr(t2_sadr), .s_dat(t2_sdat), .s_sel(t2_ssel),
      .s_we(t2_swe), .s_cyc(t2_scyc), .s_stb(t2_sstb), .s_rdt(s_rdt), .s_ack(t2_sack),
      .grant_idx(t2_gnt), .busy(t2_busy), .timeout_evt(t2_evt));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      m_cyc     = '0;
      s_ack_drv = 1'b0;
      zw        = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Round-robin winner: the requester at the smallest forward distance from the pointer.
   function automatic int mdl_pick(input logic [N-1:0] req, input int from);
      int best   = -1;
      int best_d = N;
      for (int j = 0; j < N; j++) begin
         if (req[j] && ((j - from + N) % N) < best_d) begin
            best   = j;
            best_d = (j - from + N) % N;
         end
      end
      return best;
   endfunction

   typedef struct packed {
      logic [N-1:0]  req;
      logic [1:0]    gnt;
      logic [AW-1:0] adr;
   } vec_t;

   vec_t tbl [8];

   int           owner, age, ptr, last_g, eg;
   logic         live, acked, timed, eb, e_scyc, e_evt;
   logic [N-1:0] e_ack, e_err, done;

   initial begin
      tbl[0] = '{4'b0001, 2'd0, 32'h0000_1000};
      tbl[1] = '{4'b0010, 2'd1, 32'h0000_2000};
      tbl[2] = '{4'b1100, 2'd2, 32'h0000_3000};
      tbl[3] = '{4'b1000, 2'd3, 32'h0000_4000};
      tbl[4] = '{4'b1111, 2'd0, 32'h0000_1000};
      tbl[5] = '{4'b1010, 2'd1, 32'h0000_2000};
      tbl[6] = '{4'b0110, 2'd1, 32'h0000_2000};
      tbl[7] = '{4'b0101, 2'd0, 32'h0000_1000};

      m_we  = '0;
      m_sel = '1;
      s_rdt = '0;
      for (int i = 0; i < N; i++) begin
         m_adr[i*AW +: AW] = 32'h1000 * (i + 1);
         m_dat[i*DW +: DW] = 32'hD000_0000 + i;
      end

      // Reset state of all three instances.
      do_reset();
      @(negedge clk);
      check("reset_rr", {rr_busy, rr_gnt, rr_scyc, rr_sstb, rr_ack, rr_err, rr_evt}, '0);
      check("reset_fx", {fx_busy, fx_gnt, fx_scyc, fx_sstb, fx_ack, fx_err, fx_evt}, '0);
      check("reset_t2", {t2_busy, t2_gnt, t2_scyc, t2_sstb, t2_ack, t2_err, t2_evt}, '0);

      // Fixed-priority grant table, one acked transfer per entry.
      tick();
      for (int v = 0; v < 8; v++) begin
         m_cyc = tbl[v].req;
         tick();
         @(negedge clk);
         check("tbl_grant", {fx_busy, fx_gnt, fx_scyc, fx_sadr}, {1'b1, tbl[v].gnt, 1'b1, tbl[v].adr});
         s_ack_drv = 1'b1;
         #1;
         check("tbl_ack", fx_ack, 4'b0001 << tbl[v].gnt);
         tick();
         s_ack_drv = 1'b0;
         m_cyc     = '0;
      end

      // Single master on the 2-port instance, slave acks in the third BUSY cycle.
      do_reset();
      m_adr[AW +: AW] = 32'h0000_0100;
      m_cyc           = 4'b0010;
      #1;
      check("single_pre", t2_scyc, 1'b0);
      tick();
      @(negedge clk);
      check("single_req", {t2_busy, t2_gnt, t2_scyc, t2_sadr}, {1'b1, 1'b1, 1'b1, 32'h0000_0100});
      check("single_wait1", t2_ack, 2'b00);
      tick();
      @(negedge clk);
      check("single_wait2", t2_ack, 2'b00);
      tick();
      s_ack_drv = 1'b1;
      s_rdt     = 32'hCAFE_F00D;
      @(negedge clk);
      check("single_ack", {t2_ack, t2_rdt}, {2'b10, 32'hCAFE_F00D});
      tick();
      s_ack_drv = 1'b0;
      m_cyc     = '0;
      @(negedge clk);
      check("single_done", {t2_busy, t2_ack, t2_scyc}, '0);
      m_adr[AW +: AW] = 32'h0000_2000;

      // All four masters requesting continuously with a zero-wait slave.
      do_reset();
      zw    = 1'b1;
      m_cyc = 4'b1111;
      for (int k = 1; k <= 10; k++) begin
         tick();
         @(negedge clk);
         eb = (k % 2 == 1);
         eg = ((k - 1) / 2) % 4;
         check("fixed_prio", {fx_busy, fx_gnt, fx_ack}, {eb, 2'd0, eb ? 4'b0001 : 4'b0000});
         check("rr_order", {rr_busy, rr_gnt, rr_ack}, {eb, 2'(eg), eb ? (4'b0001 << eg) : 4'b0000});
      end

      // Watchdog: slave never acks, m1 and m2 requesting.
      do_reset();
      m_cyc = 4'b0110;
      for (int k = 1; k <= TO; k++) begin
         tick();
         @(negedge clk);
         eb = (k == TO);
         check("timeout_rr", {rr_busy, rr_gnt, rr_scyc, rr_err, rr_evt},
               {1'b1, 2'd1, !eb, eb ? 4'b0010 : 4'b0000, eb});
         check("timeout_fx", {fx_busy, fx_gnt, fx_scyc, fx_err, fx_evt},
               {1'b1, 2'd1, !eb, eb ? 4'b0010 : 4'b0000, eb});
      end
      tick();
      m_cyc = 4'b0100;
      @(negedge clk);
      check("timeout_idle", {rr_busy, rr_err, rr_evt, fx_busy, fx_err, fx_evt}, '0);
      tick();
      @(negedge clk);
      check("timeout_next_rr", {rr_busy, rr_gnt}, {1'b1, 2'd2});
      check("timeout_next_fx", {fx_busy, fx_gnt}, {1'b1, 2'd2});

      // Ack arriving in the same cycle the watchdog would fire.
      do_reset();
      m_cyc = 4'b0001;
      for (int k = 1; k < TO; k++) tick();
      tick();
      s_ack_drv = 1'b1;
      @(negedge clk);
      check("ack_vs_to_rr", {rr_ack, rr_err, rr_evt, rr_scyc}, {4'b0001, 4'b0000, 1'b0, 1'b1});
      check("ack_vs_to_fx", {fx_ack, fx_err, fx_evt, fx_scyc}, {4'b0001, 4'b0000, 1'b0, 1'b1});

      // Reset asserted in the middle of a transfer.
      do_reset();
      m_cyc = 4'b0001;
      tick();
      @(negedge clk);
      check("rst_pre", {rr_busy, rr_scyc}, 2'b11);
      rst_n = 1'b0;
      tick();
      s_ack_drv = 1'b1;
      @(negedge clk);
      check("rst_mid", {rr_busy, rr_scyc, rr_sstb, rr_ack, rr_err, rr_gnt}, '0);
      rst_n     = 1'b1;
      s_ack_drv = 1'b0;
      m_cyc     = '0;

      // Granted master drops its request while the slave acks.
      do_reset();
      m_cyc = 4'b0001;
      tick();
      m_cyc     = '0;
      s_ack_drv = 1'b1;
      @(negedge clk);
      check("drop_busy", {rr_busy, rr_scyc, rr_ack, fx_busy, fx_scyc, fx_ack},
            {1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000});
      tick();
      s_ack_drv = 1'b0;
      @(negedge clk);
      check("drop_idle", {rr_busy, rr_ack, fx_busy, fx_ack}, '0);

      // Randomized traffic on the round-robin instance against the transfer model.
      do_reset();
      owner  = -1;
      age    = 0;
      ptr    = 0;
      last_g = 0;
      done   = '0;
      for (int c = 0; c < 2000; c++) begin
         s_ack_drv = ($urandom_range(2) == 0);
         s_rdt     = $urandom();
         for (int i = 0; i < N; i++) begin
            if (done[i]) begin
               m_cyc[i] = 1'b0;
            end else if (m_cyc[i]) begin
               if ($urandom_range(39) == 0) m_cyc[i] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               m_cyc[i]          = 1'b1;
               m_adr[i*AW +: AW] = $urandom();
               m_dat[i*DW +: DW] = $urandom();
               m_sel[i*SW +: SW] = 4'($urandom());
               m_we[i]           = 1'($urandom());
            end
         end
         @(negedge clk);
         eb     = (owner >= 0);
         e_ack  = '0;
         e_err  = '0;
         e_evt  = 1'b0;
         e_scyc = 1'b0;
         live   = 1'b0;
         acked  = 1'b0;
         timed  = 1'b0;
         if (owner >= 0) begin
            live   = m_cyc[owner];
            acked  = live && s_ack_drv;
            timed  = live && !s_ack_drv && (age == TO - 1);
            e_scyc = live && !timed;
            if (acked) e_ack[owner] = 1'b1;
            if (timed) begin
               e_err[owner] = 1'b1;
               e_evt        = 1'b1;
            end
            check("rand_fields", {rr_sadr, rr_sdat, rr_ssel, rr_swe},
                  {m_adr[owner*AW +: AW], m_dat[owner*DW +: DW], m_sel[owner*SW +: SW], m_we[owner]});
         end
         check("rand_ctl", {rr_busy, rr_gnt, rr_scyc, rr_sstb, rr_ack, rr_err, rr_evt, rr_rdt},
               {eb, 2'(last_g), e_scyc, e_scyc, e_ack, e_err, e_evt, s_rdt});
         if (owner < 0) begin
            eg = mdl_pick(m_cyc, ptr);
            if (eg >= 0) begin
               owner  = eg;
               last_g = eg;
               age    = 0;
               ptr    = (eg + 1) % N;
            end
         end else if (!live || acked || timed) begin
            owner = -1;
         end else begin
            age++;
         end
         done = e_ack | e_err;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_mux_arbiter.md
# wb_mux_arbiter

Parametrised Wishbone classic arbiter that merges `NUM_MASTERS` single-transfer masters onto one shared slave port. It replaces the fixed two-port ibus/dbus arbiter in the SERV-based SoC so that extra masters (DMA, debug) can share the CPU's memory path. It adds selectable fixed or round-robin priority and a bus-timeout watchdog that aborts hung transfers with an error.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of master ports, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, a multiple of 8. `SEL_W = DATA_W/8`.
- `ARB_MODE`, "RR": "RR" selects round-robin, "FIXED" makes the lowest index win.
- `TIMEOUT`, 256: number of BUSY cycles without ack before the transfer is aborted. 0 disables the watchdog.

Ports:
- `wb_clk` in 1: the single clock.
- `wb_rst` in 1: reset, synchronous and active-low.
- `m_adr` in NUM_MASTERS*ADDR_W: master addresses. Master i occupies slice [i*ADDR_W +: ADDR_W].
- `m_dat` in NUM_MASTERS*DATA_W: master write data.
- `m_sel` in NUM_MASTERS*SEL_W: master byte selects.
- `m_we` in NUM_MASTERS: master write enables.
- `m_cyc` in NUM_MASTERS: master requests. STB is implied by CYC.
- `m_rdt` out DATA_W: read data, broadcast to all masters.
- `m_ack` out NUM_MASTERS: per-master ack.
- `m_err` out NUM_MASTERS: per-master timeout error.
- `s_adr`, `s_dat`, `s_sel`, `s_we` out: slave-side request fields, widths as above.
- `s_cyc` out 1, `s_stb` out 1: slave cycle and strobe. `s_stb = s_cyc`.
- `s_rdt` in DATA_W, `s_ack` in 1: slave read data and ack.
- `grant_idx` out clog2(NUM_MASTERS): index of the granted master, for debug.
- `busy` out 1: a transfer is in flight.
- `timeout_evt` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM has two states:
  - IDLE → BUSY when any `m_cyc` is high. The winner is registered into `grant_idx`.
  - BUSY → IDLE on `s_ack`, on a timeout, or when the granted master drops `m_cyc` (abort, no ack is issued).
- There is exactly one transfer per grant. The FSM re-arbitrates in IDLE after every transfer.
- Priority:
  - FIXED: the lowest requesting index wins.
  - RR: the search starts at `ptr`. After granting i, `ptr = (i+1) mod NUM_MASTERS`. `ptr` does not change when nobody is granted.
- In BUSY, the `s_*` request fields are driven from master `grant_idx`, and `s_cyc = m_cyc[grant_idx] & ~abort`.
- In IDLE, `s_cyc = 0` and the other `s_*` fields are don't-care, held at the last grant.
- Responses:
  - `m_ack[grant_idx] = s_ack & busy`. `m_rdt = s_rdt`, combinational pass-through.
  - All other `m_ack` and `m_err` bits are 0.
- Watchdog:
  - `wdt` counter is cleared on entry to BUSY and increments each BUSY cycle.
  - When `wdt == TIMEOUT-1` and there is no `s_ack`: assert `m_err[grant_idx]` and `timeout_evt` for that cycle, force `s_cyc = 0` (abort), and go to IDLE.
  - Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- Simultaneous events:
  - `s_ack` in the same cycle as the timeout: the ack wins, with no err and no evt.
  - `s_ack` in the same cycle as the master dropping `m_cyc`: no ack is delivered and the FSM goes to IDLE.
- Masters must deassert `m_cyc` in the cycle after their ack or err. A still-high `m_cyc` is treated as a new request.

## Timing
- Reset, active while `wb_rst` is low at a clock edge:
  - State IDLE; `grant_idx=0`, `ptr=0`, `wdt=0`, `busy=0`.
  - `s_cyc=0`, `s_stb=0`, `m_ack=0`, `m_err=0`, `timeout_evt=0`.
  - Reset in the middle of a transfer drops `s_cyc` from the next edge. No ack is forwarded.
- Latency:
  - A request seen in IDLE at edge n gives `s_cyc` high in cycle n+1.
  - Ack reaches the master in the same cycle as `s_ack`, combinationally.
  - Minimum of 2 cycles per transfer, plus 1 IDLE cycle between grants.
- Timeout: `m_err` is asserted in the TIMEOUT-th BUSY cycle. `s_cyc` is low in that same cycle.
- `grant_idx`, `busy` and `ptr` are registered. `m_ack`, `m_err`, `m_rdt` and all `s_*` outputs are combinational from state and inputs.

## Structure
- Package `wb_arb_pkg` holds:
  - The state enum (IDLE, BUSY).
  - The mode constants `ARB_FIXED` and `ARB_RR`.
  - A `clog2` function.
- Sub-module `wb_arb_pick` is purely combinational. It takes `req[N]`, `ptr` and the mode, and returns `valid` and `idx` from a rotating priority encoder.
- The top level contains the FSM, the grant/ptr/wdt registers and the muxes.

## Test plan
- Single master: NUM_MASTERS=2, FIXED mode; m1 reads 0x100 and the slave acks with 0xCAFEF00D after 3 cycles. Required: `s_adr=0x100`, m1 gets `m_ack` with `m_rdt=0xCAFEF00D`, and `s_cyc` is first seen one cycle after the request.
- Fixed priority: all 4 masters request continuously in FIXED mode. Required: m0 is granted every transfer and the others stall.
- Round-robin: all 4 masters request continuously in RR mode, zero-wait slave. Required: grant order is 0,1,2,3,0, with one IDLE cycle between grants.
- Timeout: TIMEOUT=8 and the slave never acks. Required: `m_err` and `timeout_evt` pulse in BUSY cycle 8, `s_cyc` is low in that cycle, and the next master is granted afterwards.
- Ack versus timeout: `s_ack` arrives in BUSY cycle 8 with TIMEOUT=8. Required: `m_ack=1`, `m_err=0`, `timeout_evt=0`.
- Reset and abort:
  - `wb_rst` pulled low mid-transfer: required `s_cyc=0` and `busy=0` next cycle, no ack.
  - Master drops `m_cyc` in BUSY: required return to IDLE with no ack delivered.
